hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage ARM pipeline. Drives Exec's forwardAE/forwardBE
//  mux selects and the stall/flush lines for the F/D/E pipe registers. Covers load-use stalls,
//  PC-write and branch flushes, and an FSM that holds Exec for multicycle ops (MUL).
//  Also counts stall cycles for performance.
// PARAMETERS
//  MC_LAT   3   cycles a multicycle op occupies Exec (legal range 2..15)
//  CNT_W    16  width of the saturating stall-cycle counter
// PORTS
//  clk            in   1      pipeline clock
//  reset          in   1      synchronous, active-high
//  RA1D, RA2D     in   4      source register addresses in Decode
//  RA1E, RA2E     in   4      source register addresses in Exec
//  RdE, RdM, RdW  in   4      destination register addresses in E/M/W
//  RegWriteM/W    in   1      destination write enable in M/W
//  MemtoRegE      in   1      Exec instruction is a load
//  PCWrPendingF   in   1      PC-writing instruction present in D, E or M
//  PCSrcW         in   1      PC write commits in Writeback
//  BranchTakenE   in   1      condition-passed branch in Exec
//  MCStartE       in   1      condition-passed multicycle op enters Exec
//  forwardAE/BE   out  2      00 = regfile, 01 = ResultW, 10 = ALUResultM
//  StallF/D/E     out  1      hold the F, D or E pipe register
//  FlushD/E       out  1      clear the D or E pipe register (bubble)
//  MCBusy         out  1      multicycle op in progress
//  MCDoneE        out  1      one-cycle pulse: multicycle result valid in Exec
//  StallCycles    out  CNT_W  saturating count of cycles with StallF=1
// BEHAVIOUR
//  - Reset: FSM goes to IDLE, counter=0, StallCycles=0. While reset=1 the outputs are
//    forward=00, Stall*=0, FlushD=FlushE=1, MCBusy=0, MCDoneE=0.
//  - Forwarding (combinational, 0 latency), per operand X in {1,2}:
//    if RegWriteM & RAXE==RdM & RAXE!=15, select 10;
//    else if RegWriteW & RAXE==RdW & RAXE!=15, select 01; else 00.
//    M has priority over W. R15 is never forwarded.
//  - ldrStall = MemtoRegE & (RA1D==RdE | RA2D==RdE).
//  - FSM states IDLE -> BUSY -> DONE -> IDLE:
//    IDLE->BUSY on MCStartE, loading cnt=MC_LAT-2;
//    BUSY decrements cnt and moves to DONE when cnt==0;
//    DONE lasts 1 cycle. Total Exec occupancy is exactly MC_LAT cycles.
//    MCBusy=1 when state is BUSY, or when state is IDLE and MCStartE=1.
//    MCDoneE=1 in DONE only.
//  - mcStall = MCBusy. In DONE, E advances normally.
//  - StallF = ldrStall | PCWrPendingF | mcStall
//  - StallD = ldrStall | mcStall
//  - StallE = mcStall
//  - FlushE = (ldrStall | BranchTakenE) & ~mcStall
//    A busy multicycle op is never flushed; a pending ldrStall just holds D.
//  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE
//  - Simultaneous events:
//    * StallD and FlushD both high: flush wins.
//    * BranchTakenE & MCStartE together is illegal (same E slot): assertion, branch wins, FSM stays IDLE.
//    * PCSrcW or BranchTakenE while in BUSY is illegal: assertion.
//  - Counter: StallCycles increments each cycle StallF=1, saturates at all-ones, never wraps.
//  - Reset mid-op (in BUSY/DONE): IDLE on the next edge, no MCDoneE pulse, counter cleared.
// STRUCTURE
//  - hazard_pkg holds:
//    * fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
//    * mc_state_t enum: IDLE, BUSY, DONE
//    * localparam PC_REG=4'd15
//  - One sub-module, mc_sequencer: the FSM plus the down-counter. It takes clk, reset and
//    MCStartE and produces MCBusy and MCDoneE.
//  - Forwarding, stall/flush equations and the stall counter live in hazard_ctrl.
// TESTING
//  1. RdM=3, RegWriteM=1, RdW=3, RegWriteW=1, RA1E=3 -> forwardAE=10.
//     Drop RegWriteM -> forwardAE=01.
//     RA1E=15 with RdM=15 -> 00.
//  2. MemtoRegE=1, RdE=5, RA2D=5 -> StallF=StallD=FlushE=1 for exactly 1 cycle,
//     then all 0 once the load moves to M.
//  3. MCStartE pulse, MC_LAT=3 -> MCBusy=1 for 2 cycles, MCDoneE=1 on the 3rd,
//     StallE=1 for 2 cycles, FlushE=0 throughout.
//  4. MCStartE with ldrStall raised during BUSY -> StallD=1, FlushE=0 until DONE,
//     then FlushE=1 for 1 cycle.
//  5. BranchTakenE=1 -> FlushD=FlushE=1, StallF=0.
//     PCWrPendingF=1 for 3 cycles then PCSrcW=1 -> StallF=1 for 3 cycles, FlushD=1 for 4.
//  6. reset in cycle 2 of BUSY (MC_LAT=4) -> IDLE next edge, no MCDoneE pulse, StallCycles=0.
//     Hold StallF=1 with CNT_W=4 for 20 cycles -> count saturates at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and forwarding helper for the hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mc_state_t;

  localparam logic [3:0] PC_REG = 4'd15;

  // Memory stage result is newer than writeback, so it wins; R15 is read from the PC path, never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic       rw_m,
    input logic [3:0] rd_m,
    input logic       rw_w,
    input logic [3:0] rd_w,
    input logic [3:0] ra
  );
    if (rw_m && (ra == rd_m) && (ra != PC_REG)) begin
      return FWD_M;
    end
    if (rw_w && (ra == rd_w) && (ra != PC_REG)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - holds Exec for a multicycle op for exactly MC_LAT cycles
module mc_sequencer
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic MCStartE,
  output logic MCBusy,
  output logic MCDoneE
);

  // Busy cycles are the start cycle plus (MC_LAT-2) BUSY cycles; DONE adds the last one.
  localparam logic [3:0] LOAD = 4'(MC_LAT - 2);

  mc_state_t  r_state;
  mc_state_t  w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  // State and down-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter update and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    MCBusy      = 1'b0;
    MCDoneE     = 1'b0;
    case (r_state)
      IDLE: begin
        if (MCStartE) begin
          MCBusy      = 1'b1;
          w_cnt_nxt   = LOAD;
          w_state_nxt = (LOAD == 4'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        MCBusy = 1'b1;
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DONE: begin
        MCDoneE     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding selects, stall/flush lines and stall-cycle counter
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       RdE,
  input  logic [3:0]       RdM,
  input  logic [3:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCWrPendingF,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MCStartE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MCBusy,
  output logic             MCDoneE,
  output logic [CNT_W-1:0] StallCycles
);

  logic             w_mc_start;
  logic             w_mc_busy;
  logic             w_mc_done;
  logic             w_ldr_stall;
  logic             w_mc_stall;
  logic [CNT_W-1:0] r_stall_cnt;

  // A taken branch owns the Exec slot, so it suppresses a simultaneous multicycle start.
  assign w_mc_start  = MCStartE & ~BranchTakenE;
  assign w_ldr_stall = MemtoRegE & ((RA1D == RdE) | (RA2D == RdE));
  assign w_mc_stall  = w_mc_busy;

  mc_sequencer #(
    .MC_LAT (MC_LAT)
  ) u_mc_seq (
    .clk      (clk),
    .reset    (reset),
    .MCStartE (w_mc_start),
    .MCBusy   (w_mc_busy),
    .MCDoneE  (w_mc_done)
  );

  // Forwarding and stall/flush outputs; reset forces bubbles into D and E.
  always_comb begin
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    MCBusy    = 1'b0;
    MCDoneE   = 1'b0;
    if (!reset) begin
      forwardAE = fwd_select(RegWriteM, RdM, RegWriteW, RdW, RA1E);
      forwardBE = fwd_select(RegWriteM, RdM, RegWriteW, RdW, RA2E);
      StallF    = w_ldr_stall | PCWrPendingF | w_mc_stall;
      StallD    = w_ldr_stall | w_mc_stall;
      StallE    = w_mc_stall;
      FlushE    = (w_ldr_stall | BranchTakenE) & ~w_mc_stall;
      FlushD    = PCWrPendingF | PCSrcW | BranchTakenE;
      MCBusy    = w_mc_busy;
      MCDoneE   = w_mc_done;
    end
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (StallF && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign StallCycles = r_stall_cnt;

  // Illegal event combinations: branch with multicycle start, PC redirect while Exec is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(BranchTakenE && MCStartE));
      assert (!(w_mc_busy && !w_mc_start && (PCSrcW || BranchTakenE)));
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, reset4;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE;
  logic       MCStartE, MCStartE4;

  logic [1:0]  fwdA, fwdB, fwdA4, fwdB4;
  logic        stallF, stallD, stallE, flushD, flushE, busy, done;
  logic        stallF4, stallD4, stallE4, flushD4, flushE4, busy4, done4;
  logic [15:0] cyc;
  logic [3:0]  cyc4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_LAT(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MCStartE(MCStartE),
    .forwardAE(fwdA), .forwardBE(fwdB), .StallF(stallF), .StallD(stallD), .StallE(stallE),
    .FlushD(flushD), .FlushE(flushE), .MCBusy(busy), .MCDoneE(done), .StallCycles(cyc)
  );

  hazard_ctrl #(.MC_LAT(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset4), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MCStartE(MCStartE4),
    .forwardAE(fwdA4), .forwardBE(fwdB4), .StallF(stallF4), .StallD(stallD4), .StallE(stallE4),
    .FlushD(flushD4), .FlushE(flushE4), .MCBusy(busy4), .MCDoneE(done4), .StallCycles(cyc4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    RA1D = 4'd1; RA2D = 4'd2; RA1E = 4'd1; RA2E = 4'd2;
    RdE = 4'd0; RdM = 4'd0; RdW = 4'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCWrPendingF = 1'b0; PCSrcW = 1'b0; BranchTakenE = 1'b0;
    MCStartE = 1'b0; MCStartE4 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset4 = 1'b1;
    quiet();
    tick(); tick();

    // reset state with hazards on the inputs
    MCStartE = 1'b1; PCWrPendingF = 1'b1; RegWriteM = 1'b1; RdM = 4'd1;
    #1;
    chk("rst_fwdA", fwdA, 2'b00);
    chk("rst_stallF", stallF, 1'b0);
    chk("rst_stallE", stallE, 1'b0);
    chk("rst_flushD", flushD, 1'b1);
    chk("rst_flushE", flushE, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", cyc, 16'd0);
    tick();
    quiet();
    reset = 1'b0; reset4 = 1'b0;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_done", done, 1'b0);
    chk("post_rst_flushD", flushD, 1'b0);
    chk("post_rst_flushE", flushE, 1'b0);
    chk("post_rst_cnt", cyc, 16'd0);

    // forwarding priority and R15 exclusion
    RdM = 4'd3; RegWriteM = 1'b1; RdW = 4'd3; RegWriteW = 1'b1; RA1E = 4'd3;
    #1;
    chk("fwd_m", fwdA, 2'b10);
    chk("fwd_b_none", fwdB, 2'b00);
    RegWriteM = 1'b0; RA2E = 4'd3;
    #1;
    chk("fwd_w", fwdA, 2'b01);
    chk("fwd_b_w", fwdB, 2'b01);
    RegWriteM = 1'b1; RA1E = 4'd15; RdM = 4'd15;
    #1;
    chk("fwd_r15_m", fwdA, 2'b00);
    RdM = 4'd4; RdW = 4'd15; RA2E = 4'd15;
    #1;
    chk("fwd_r15_w", fwdB, 2'b00);
    quiet();

    // load-use stall for one cycle
    MemtoRegE = 1'b1; RdE = 4'd5; RA2D = 4'd5;
    #1;
    chk("ldr_stallF", stallF, 1'b1);
    chk("ldr_stallD", stallD, 1'b1);
    chk("ldr_flushE", flushE, 1'b1);
    chk("ldr_stallE", stallE, 1'b0);
    chk("ldr_flushD", flushD, 1'b0);
    tick();
    MemtoRegE = 1'b0; RdE = 4'd0;
    #1;
    chk("ldr_end_stallF", stallF, 1'b0);
    chk("ldr_end_stallD", stallD, 1'b0);
    chk("ldr_end_flushE", flushE, 1'b0);
    chk("ldr_cnt", cyc, 16'd1);

    // multicycle op, MC_LAT=3
    MCStartE = 1'b1;
    #1;
    chk("mc_c0_busy", busy, 1'b1);
    chk("mc_c0_stallE", stallE, 1'b1);
    chk("mc_c0_flushE", flushE, 1'b0);
    chk("mc_c0_done", done, 1'b0);
    tick();
    MCStartE = 1'b0;
    #1;
    chk("mc_c1_busy", busy, 1'b1);
    chk("mc_c1_stallE", stallE, 1'b1);
    chk("mc_c1_flushE", flushE, 1'b0);
    tick();
    chk("mc_c2_done", done, 1'b1);
    chk("mc_c2_busy", busy, 1'b0);
    chk("mc_c2_stallE", stallE, 1'b0);
    chk("mc_c2_flushE", flushE, 1'b0);
    tick();
    chk("mc_c3_done", done, 1'b0);
    chk("mc_cnt", cyc, 16'd3);

    // load-use raised while the multicycle op is busy
    MCStartE = 1'b1;
    #1;
    chk("mcl_c0_busy", busy, 1'b1);
    tick();
    MCStartE = 1'b0; MemtoRegE = 1'b1; RdE = 4'd6; RA1D = 4'd6;
    #1;
    chk("mcl_c1_stallD", stallD, 1'b1);
    chk("mcl_c1_flushE", flushE, 1'b0);
    chk("mcl_c1_stallE", stallE, 1'b1);
    tick();
    chk("mcl_c2_done", done, 1'b1);
    chk("mcl_c2_stallD", stallD, 1'b1);
    chk("mcl_c2_flushE", flushE, 1'b1);
    chk("mcl_c2_stallE", stallE, 1'b0);
    tick();
    quiet();
    #1;
    chk("mcl_c3_flushE", flushE, 1'b0);
    chk("mcl_c3_stallD", stallD, 1'b0);
    chk("mcl_cnt", cyc, 16'd6);

    // branch and PC-write flushes
    BranchTakenE = 1'b1;
    #1;
    chk("br_flushD", flushD, 1'b1);
    chk("br_flushE", flushE, 1'b1);
    chk("br_stallF", stallF, 1'b0);
    chk("br_stallD", stallD, 1'b0);
    tick();
    BranchTakenE = 1'b0; PCWrPendingF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pcw_stallF", stallF, 1'b1);
      chk("pcw_flushD", flushD, 1'b1);
      chk("pcw_stallD", stallD, 1'b0);
      tick();
    end
    PCWrPendingF = 1'b0; PCSrcW = 1'b1;
    #1;
    chk("pcsrc_stallF", stallF, 1'b0);
    chk("pcsrc_flushD", flushD, 1'b1);
    tick();
    PCSrcW = 1'b0;
    #1;
    chk("pc_end_flushD", flushD, 1'b0);
    chk("pc_cnt", cyc, 16'd9);

    // reset during BUSY on the MC_LAT=4 instance
    MCStartE4 = 1'b1;
    #1;
    chk("r4_c0_busy", busy4, 1'b1);
    tick();
    MCStartE4 = 1'b0;
    #1;
    chk("r4_c1_busy", busy4, 1'b1);
    tick();
    chk("r4_c2_busy", busy4, 1'b1);
    reset4 = 1'b1;
    #1;
    chk("r4_rst_busy", busy4, 1'b0);
    chk("r4_rst_done", done4, 1'b0);
    chk("r4_rst_flushD", flushD4, 1'b1);
    tick();
    reset4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("r4_after_done", done4, 1'b0);
      chk("r4_after_busy", busy4, 1'b0);
      tick();
    end
    chk("r4_cnt_clr", cyc4, 4'd0);

    // saturation of the 4-bit counter
    PCWrPendingF = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("sat_cnt4", cyc4, (i > 15) ? 32'd15 : 32'(i));
    end
    PCWrPendingF = 1'b0;
    chk("sat_cnt16", cyc, 16'd29);
    tick();
    chk("sat_hold4", cyc4, 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
